// File: rtl/sdrc_arb_pkg.sv
// sdrc_arb_pkg: shared types and Wishbone cycle-type constants for the SDRAM arbiter
package sdrc_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req at or after ptr wins
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW:0]   sum;
  logic [PW-1:0] j;
  assign any = |req;
  // Walk offsets from farthest to nearest so the entry closest to ptr overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    sum = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      j   = sum >= (PW+1)'(N) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/sdrc_wb_arb.sv
// sdrc_wb_arb: round-robin Wishbone arbiter sharing one sdrc_top slave port among NUM_M masters
module sdrc_wb_arb
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_M     = 4,
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int STALL_MAX = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_addr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  input  logic [NUM_M*3-1:0]      m_cti_i,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [DW-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_addr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic [2:0]              s_cti_o,
  input  logic                    s_ack_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [NUM_M-1:0]        gnt_o,
  output logic                    timeout_o
);
  localparam int PW = $clog2(NUM_M);
  localparam int SW = DW / 8;
  state_t            state, state_nx;
  logic [NUM_M-1:0]  req, win, gnt_nx;
  logic [PW-1:0]     idx, idx_nx, win_idx, ptr, ptr_nx;
  logic              any_req, busy, leave, stall, wrap;
  logic [7:0]        cnt;
  logic [8:0]        cnt_inc;
  assign req   = m_cyc_i & m_stb_i;
  assign busy  = state == BUSY;
  assign leave = busy & ~|(m_cyc_i & gnt_o);
  rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (win),
    .idx (win_idx),
    .any (any_req)
  );
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_o;
    idx_nx   = idx;
    ptr_nx   = ptr;
    if (!busy && any_req) begin
      state_nx = BUSY;
      gnt_nx   = win;
      idx_nx   = win_idx;
    end else if (leave) begin
      state_nx = IDLE;
      gnt_nx   = '0;
      ptr_nx   = idx == PW'(NUM_M - 1) ? '0 : idx + 1'b1;
    end
  end
  // gnt_o is zero outside BUSY, so this AND-OR mux also forces the idle/reset zeros
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_o[i]) begin
        s_cyc_o  = m_cyc_i[i];
        s_stb_o  = m_stb_i[i];
        s_we_o   = m_we_i[i];
        s_addr_o = m_addr_i[i*AW +: AW];
        s_dat_o  = m_dat_i[i*DW +: DW];
        s_sel_o  = m_sel_i[i*SW +: SW];
        s_cti_o  = m_cti_i[i*3 +: 3];
      end
    end
  end
  assign m_ack_o = gnt_o & {NUM_M{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign stall   = busy & s_stb_o & ~s_ack_i;
  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign wrap    = cnt_inc == 9'(STALL_MAX);
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      idx       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nx;
      gnt_o     <= gnt_nx;
      idx       <= idx_nx;
      ptr       <= ptr_nx;
      cnt       <= (!stall || leave || wrap) ? '0 : cnt_inc[7:0];
      timeout_o <= stall & ~leave & wrap;
    end
  end
endmodule

// File: doc/sdrc_wb_arb.md
Name: sdrc_wb_arb

Overview:
- Round-robin Wishbone arbiter that shares the single Wishbone slave port of sdrc_top among NUM_M masters (e.g. CPU, DMA, video fetch).
- Sits between the masters and sdrc_top, in the wb_clk_i domain.
- Grant is held for a complete Wishbone cycle (cyc high), so classic and incrementing bursts (cti) are never split.
- Includes a per-grant stall watchdog for bring-up debug.

Parameters:
- NUM_M, 4, number of masters (2..8).
- AW, 26, Wishbone address width.
- DW, 32, Wishbone data width; byte-select width is DW/8.
- STALL_MAX, 255, cycles a granted strobe may wait for ack before timeout_o pulses (8-bit counter range).

Ports:
- wb_clk_i  in  1  system/Wishbone clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_M  per-master cycle.
- m_stb_i  in  NUM_M  per-master strobe.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*AW  packed addresses; master i at [i*AW +: AW].
- m_dat_i  in  NUM_M*DW  packed write data.
- m_sel_i  in  NUM_M*DW/8  packed byte selects.
- m_cti_i  in  NUM_M*3  packed cycle-type identifiers.
- m_ack_o  out  NUM_M  per-master ack.
- m_dat_o  out  DW  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to sdrc_top.
- s_addr_o  out  AW.
- s_dat_o  out  DW.
- s_sel_o  out  DW/8.
- s_cti_o  out  3.
- s_ack_i  in  1  from sdrc_top.
- s_dat_i  in  DW  from sdrc_top.
- gnt_o  out  NUM_M  one-hot current grant.
- timeout_o  out  1  one-cycle stall-watchdog pulse.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - State IDLE, gnt_o=0, round-robin pointer ptr=0, stall counter=0, timeout_o=0.
  - All s_* outputs 0 and m_ack_o=0 while in reset.
- States: IDLE, BUSY.
- IDLE:
  - s_cyc_o=s_stb_o=0; all other s_* outputs 0.
  - req[i] = m_cyc_i[i] & m_stb_i[i].
  - If any req, the winner is the first set req searching ptr, ptr+1, ... mod NUM_M.
  - gnt_o is registered to the winner's one-hot; go to BUSY. Latency: request at edge k, s_cyc_o high after edge k+1.
  - No req: stay in IDLE.
- BUSY (granted index g):
  - s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g]; s_we/addr/dat/sel/cti from master g. Combinational mux from the registered grant.
  - m_ack_o[g]=s_ack_i; all other m_ack_o bits 0.
  - m_dat_o=s_dat_i at all times.
  - Exit when m_cyc_i[g]=0: next state IDLE, gnt_o<=0, ptr<=(g+1) mod NUM_M.
  - The mandatory IDLE cycle guarantees at least one cycle with s_cyc_o=0 between different masters' cycles.
- Ungranted masters wait with stb held; they never see ack.
- s_ack_i in IDLE is ignored (not forwarded).
- Simultaneous events:
  - Granted master drops cyc while another master raises req: go to IDLE, arbitrate on the next edge with the updated ptr.
  - Granted master drops cyc and re-requests immediately: it competes in IDLE and is lowest priority (ptr moved past it).
- Stall watchdog:
  - In BUSY, the counter increments each cycle with s_stb_o=1 and s_ack_i=0.
  - The counter clears on ack, on stb low, and on leaving BUSY.
  - When the counter reaches STALL_MAX, timeout_o pulses for one cycle and the counter restarts from 0.
  - Timeout does not revoke the grant.
- NUM_M not a power of 2: the pointer wraps from NUM_M-1 to 0.

Decomposition:
- Package sdrc_arb_pkg:
  - state enum (IDLE, BUSY).
  - CTI constants: CLASSIC=3'b000, INCR=3'b010, EOB=3'b111.
- Sub-module rr_pick: combinational round-robin priority selector (req, ptr -> one-hot winner plus index), reusable elsewhere in the controller.

Test Plan:
- Single master 0 write to addr 26'h0000040, data 32'hDEADBEEF, sel 4'hF, then read back -> s_cyc_o high one cycle after req; m_ack_o[0] only; read returns 32'hDEADBEEF on m_dat_o.
- Masters 0..3 all request at the same edge, each holding cyc for one classic write -> grants in order 0,1,2,3, with one s_cyc_o=0 cycle between each; ptr ends at 0.
- Master 2 performs a 4-beat INCR burst (cti 010,010,010,111) while master 1 requests -> master 1 is not granted until master 2 drops cyc after the 4th ack; gnt_o stays 4'b0100 throughout the burst.
- Master 1 ends its cycle and re-requests immediately while master 3 requests -> master 3 is granted before master 1.
- Force s_ack_i=0 with master 0 strobing, STALL_MAX=16 -> timeout_o pulses on the 16th stall cycle and again 16 cycles later; gnt_o unchanged.
- Assert wb_rst_i=0 mid-burst of master 1 -> gnt_o, s_cyc_o, s_stb_o and m_ack_o go to 0 immediately (no clock edge needed); after release, the first grant goes to the lowest requesting index.
